// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg: shared FSM state encoding and synchronizer depth for button_debounce_pulse.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_pulse_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, async active-low reset to 0.
module sync_2ff
    import button_debounce_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce_pulse.sv
// button_debounce_pulse: debounces a raw button into a level plus a one-cycle press pulse.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses while the button stays pressed.
module button_debounce_pulse
    import button_debounce_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic level_out,
    output logic pulse_out
);

    localparam int TW = $clog2(DB_CYCLES);
    localparam logic [TW-1:0] DB_LAST = TW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("button_debounce_pulse: DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    logic       w_btn_s;
    logic       w_rep_fire;
    btn_state_t r_state;
    logic [TW-1:0] r_timer;
    logic       r_level;
    logic       r_pulse;

    sync_2ff u_sync (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_d       (btn_in),
        .o_q       (w_btn_s)
    );

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rep;
    logic          r_rep_phase;

    assign w_rep_fire = r_rep == (r_rep_phase ? RP_LAST : RD_LAST);

    // Held at zero outside PRESSED, so every entry (including from WAIT_RELEASE) restarts the delay phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rep       <= '0;
            r_rep_phase <= 1'b0;
        end else if (r_state != PRESSED || !w_btn_s) begin
            r_rep       <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep       <= '0;
            r_rep_phase <= 1'b1;
        end else begin
            r_rep       <= r_rep + 1'b1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_s) begin
                        r_state <= WAIT_PRESS;
                        r_timer <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!w_btn_s) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                    end else if (r_timer == DB_LAST) begin
                        r_state <= PRESSED;
                        r_timer <= '0;
                        r_level <= 1'b1;
                        r_pulse <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= WAIT_RELEASE;
                        r_timer <= '0;
                    end else if (w_rep_fire) begin
                        r_pulse <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (w_btn_s) begin
                        r_state <= PRESSED;
                        r_timer <= '0;
                    end else if (r_timer == DB_LAST) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            endcase
        end
    end

    assign level_out = r_level;
    assign pulse_out = r_pulse;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// tb_button_debounce_pulse: directed checks of debounce latency, glitch rejection, reset and repeat behaviour.
module tb_button_debounce_pulse;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_in = 1'b0;
    logic level_out;
    logic pulse_out;

    int checks = 0;
    int errors = 0;
    int q = 0;
    int q0;
    int dbl = 0;
    logic r_prev = 1'b0;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    button_debounce_pulse #(
        .DB_CYCLES     (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_in    (btn_in),
        .level_out (level_out),
        .pulse_out (pulse_out)
    );

    always #5 clk = ~clk;

    // Downstream negedge up-counter fed by pulse_out, plus a back-to-back pulse watcher.
    always @(negedge clk) begin
        if (pulse_out) q <= q + 1;
        if (pulse_out && r_prev) dbl <= dbl + 1;
        r_prev <= pulse_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_level", level_out, 0);
        chk("rst_pulse", pulse_out, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        q0 = q;
        btn_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("press_pulse", pulse_out, 32'(i == 7));
            chk("press_level", level_out, 32'(i >= 7));
        end
        for (int i = 0; i < 13; i++) tick();
        btn_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("release_level", level_out, 32'(i < 7));
        end
        chk("press_count", q - q0, AR ? 3 : 1);

        q0 = q;
        for (int i = 0; i < 16; i++) begin
            btn_in = (i < 6) && (i % 4 < 2);
            tick();
            chk("bounce_pulse", pulse_out, 0);
            chk("bounce_level", level_out, 0);
        end
        chk("bounce_count", q - q0, 0);

        btn_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("rb_press_level", level_out, 1);
        q0 = q;
        btn_in = 1'b0;
        tick();
        tick();
        btn_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rb_level", level_out, 1);
            chk("rb_pulse", pulse_out, 0);
        end
        btn_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rb_release_level", level_out, 32'(i < 7));
        end
        chk("rb_count", q - q0, 0);

        btn_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_level", level_out, 0);
        chk("mid_rst_pulse", pulse_out, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("post_rst_pulse", pulse_out, 32'(i == 7));
        end
        reset_n = 1'b0;
        #1;
        chk("pulse_rst_pulse", pulse_out, 0);
        chk("pulse_rst_level", level_out, 0);
        btn_in = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        q0 = q;
        btn_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("ar_accept_pulse", pulse_out, 1);
        for (int j = 1; j <= 27; j++) begin
            tick();
            chk("ar_pulse", pulse_out, 32'(AR && j >= 10 && j % 5 == 0));
        end
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("ar_level", level_out, 0);
        chk("ar_count", q - q0, AR ? 5 : 1);
        chk("no_double", dbl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
